// File: rtl/led_pwm_stage.sv
// led_pwm_stage: registered PWM/blink/enable/invert conditioning of 16 LED pins.
// Blink prescaler, counter and phase exist only when LED_BLINK_EN is defined.
module led_pwm_stage #(
   parameter int PWM_BITS = 8,
   parameter int BLINK_DIV_BITS = 20
) (
   input  logic        ledclk,
   input  logic        ledrst,
   input  logic [15:0] ledin,
   input  logic        cfgcs,
   input  logic        cfgwrite,
   input  logic [1:0]  cfgaddr,
   input  logic [15:0] cfgdata,
   output logic [15:0] cfgrdata,
   output logic [15:0] ledphys
);
   logic [PWM_BITS-1:0] duty, pwmcnt;
   logic enable, invert, pwm_on, blink_phase, wr;
   logic [15:0] blinkmask, period, lit;
   assign wr = cfgcs & cfgwrite;
   assign pwm_on = (&duty) | (pwmcnt < duty);
   assign lit = {16{enable & pwm_on}} & ledin & (~blinkmask | {16{blink_phase}});
   always_ff @(posedge ledclk or posedge ledrst)
      if (ledrst) begin
         duty <= '1;
         enable <= 1'b1;
         invert <= 1'b0;
         pwmcnt <= '0;
         ledphys <= '0;
      end else begin
         pwmcnt <= pwmcnt + 1'b1;
         if (wr && cfgaddr == 2'd0) duty <= cfgdata[PWM_BITS-1:0];
         if (wr && cfgaddr == 2'd3) begin
            enable <= cfgdata[0];
            invert <= cfgdata[1];
         end
         ledphys <= lit ^ {16{invert}};
      end
`ifdef LED_BLINK_EN
   logic [BLINK_DIV_BITS-1:0] prescaler;
   logic [15:0] blinkcnt;
   logic tick;
   assign tick = &prescaler;
   // a period write restarts the blink cycle lit, overriding any same-cycle tick
   always_ff @(posedge ledclk or posedge ledrst)
      if (ledrst) begin
         prescaler <= '0;
         blinkcnt <= '0;
         blink_phase <= 1'b1;
         blinkmask <= '0;
         period <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
         if (wr && cfgaddr == 2'd1) blinkmask <= cfgdata;
         if (wr && cfgaddr == 2'd2) begin
            period <= cfgdata;
            blinkcnt <= '0;
            blink_phase <= 1'b1;
         end else if (period == '0) begin
            blinkcnt <= '0;
            blink_phase <= 1'b1;
         end else if (tick) begin
            if (blinkcnt == period - 1'b1) begin
               blinkcnt <= '0;
               blink_phase <= ~blink_phase;
            end else
               blinkcnt <= blinkcnt + 1'b1;
         end
      end
`else
   logic unused_cfg;
   assign unused_cfg = ^cfgdata;
   assign blinkmask = '0;
   assign period = '0;
   assign blink_phase = 1'b1;
`endif
   always_comb
      cfgrdata = !cfgcs ? 16'h0000 :
                 cfgaddr == 2'd0 ? 16'(duty) :
                 cfgaddr == 2'd1 ? blinkmask :
                 cfgaddr == 2'd2 ? period : {14'b0, invert, enable};
endmodule

// File: tb/tb_led_pwm_stage.sv
// tb_led_pwm_stage: directed + random checks of led_pwm_stage (PWM_BITS=4, BLINK_DIV_BITS=2)
// against a cycle-count based reference model; blink checks only with LED_BLINK_EN.
module tb_led_pwm_stage;
   logic ledclk = 1'b0, ledrst = 1'b1, cfgcs = 1'b0, cfgwrite = 1'b0;
   logic [1:0] cfgaddr = 2'd0;
   logic [15:0] ledin = 16'hFFFF, cfgdata = 16'h0000;
   logic [15:0] cfgrdata, ledphys;
   int checks = 0, failures = 0;
`ifdef LED_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   // model: t = edges since reset release, ticks = prescaler wraps since last blink restart
   int t, ticks;
   logic [3:0] m_duty;
   logic [15:0] m_mask, m_period;
   logic m_en, m_inv;

   led_pwm_stage #(.PWM_BITS(4), .BLINK_DIV_BITS(2)) dut (
      .ledclk(ledclk), .ledrst(ledrst), .ledin(ledin), .cfgcs(cfgcs), .cfgwrite(cfgwrite),
      .cfgaddr(cfgaddr), .cfgdata(cfgdata), .cfgrdata(cfgrdata), .ledphys(ledphys));

   always #5 ledclk = ~ledclk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      t = 0;
      ticks = 0;
      m_duty = 4'hF;
      m_mask = 16'h0000;
      m_period = 16'h0000;
      m_en = 1'b1;
      m_inv = 1'b0;
   endtask

   function automatic bit model_phase();
      return (m_period == 0) || (((ticks / int'(m_period)) % 2) == 0);
   endfunction

   function automatic logic [15:0] model_phys();
      logic [15:0] r;
      bit pwm;
      pwm = (m_duty == 4'hF) || ((t % 16) < int'(m_duty));
      for (int i = 0; i < 16; i++)
         r[i] = (m_en && ledin[i] && pwm && (!m_mask[i] || model_phase())) ^ m_inv;
      return r;
   endfunction

   function automatic logic [15:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0: return {12'h000, m_duty};
         2'd1: return m_mask;
         2'd2: return m_period;
         default: return {14'b0, m_inv, m_en};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag);
      logic [15:0] e, d;
      logic [1:0] a;
      logic w;
      e = model_phys();
      w = cfgcs & cfgwrite;
      a = cfgaddr;
      d = cfgdata;
      @(posedge ledclk);
      #1;
      if (w && a == 2'd0) m_duty = d[3:0];
      if (w && a == 2'd1 && BLINK) m_mask = d;
      if (w && a == 2'd3) begin
         m_en = d[0];
         m_inv = d[1];
      end
      if (w && a == 2'd2 && BLINK) begin
         m_period = d;
         ticks = 0;
      end else if (t % 4 == 3)
         ticks++;
      t++;
      chk(tag, ledphys, e);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d, input string tag);
      cfgcs = 1'b1;
      cfgwrite = 1'b1;
      cfgaddr = a;
      cfgdata = d;
      step(tag);
      cfgcs = 1'b0;
      cfgwrite = 1'b0;
   endtask

   initial begin
      int hi, lo, last, toggles;
      logic [3:0] prev;
      logic [1:0] a;
      bit cond;
      model_reset();
      repeat (3) @(posedge ledclk);
      #1;
      chk("rst_phys", ledphys, 16'h0000);
      cfgcs = 1'b1;
      cfgaddr = 2'd3;
      #1 chk("rst_ctrl", cfgrdata, 16'h0001);
      cfgaddr = 2'd0;
      #1 chk("rst_duty", cfgrdata, 16'h000F);
      cfgcs = 1'b0;
      cfgaddr = 2'd3;
      #1 chk("rd_nocs", cfgrdata, 16'h0000);
      @(posedge ledclk);
      #1 ledrst = 1'b0;
      step("post_rst0");
      step("post_rst1");
      chk("post_rst_full", ledphys, 16'hFFFF);

      ledin = 16'h00FF;
      wr(2'd0, 16'h0004, "wr_duty4");
      for (int r = 0; r < 2; r++) begin
         hi = 0;
         lo = 0;
         for (int k = 0; k < 16; k++) begin
            step("duty4");
            if (ledphys == 16'h00FF) hi++;
            else if (ledphys == 16'h0000) lo++;
         end
         chk("duty4_hi", 16'(hi), 16'd4);
         chk("duty4_lo", 16'(lo), 16'd12);
      end

      wr(2'd0, 16'hFFF0, "wr_duty0");
      for (int k = 0; k < 16; k++) begin
         step("duty0");
         chk("duty0_zero", ledphys, 16'h0000);
      end
      wr(2'd3, 16'h0003, "wr_inv");
      step("inv_next");
      chk("inv_on", ledphys, 16'hFFFF);
      wr(2'd3, 16'h0000, "wr_dis");
      step("dis_next");
      chk("inv_off", ledphys, 16'h0000);

      for (int k = 0; k < 300; k++) begin
         ledin = 16'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            a = 2'($urandom_range(0, 3));
            wr(a, (a == 2'd2) ? 16'($urandom_range(0, 3)) : 16'($urandom), "rnd_wr");
         end else
            step("rnd");
         cfgcs = 1'b1;
         cfgaddr = 2'($urandom_range(0, 3));
         #1 chk("rnd_rd", cfgrdata, model_rd(cfgaddr));
         cfgcs = 1'b0;
      end

      ledin = 16'hFFFF;
      wr(2'd3, 16'h0001, "bl_ctrl");
      wr(2'd0, 16'h000F, "bl_duty");
      wr(2'd1, 16'h000F, "bl_mask");
      wr(2'd2, 16'h0002, "bl_period");
`ifdef LED_BLINK_EN
      last = -1;
      toggles = 0;
      for (int n = 0; n < 40; n++) begin
         prev = ledphys[3:0];
         step("blink");
         chk("blink_upper", 16'(ledphys[15:4]), 16'h0FFF);
         if (ledphys[3:0] != prev) begin
            if (last >= 0) chk("blink_spacing", 16'(n - last), 16'd8);
            last = n;
            toggles++;
         end
      end
      chk("blink_toggled", 16'(toggles >= 4), 16'd1);
      for (int k = 0; k < 20 && ledphys[3:0] != 4'h0; k++) step("seek_off");
      step("off_mid");
      chk("off_before_restart", 16'(ledphys[3:0]), 16'h0000);
      wr(2'd2, 16'h0002, "restart_wr");
      step("restart");
      chk("restart_lit", 16'(ledphys[3:0]), 16'h000F);
      for (int k = 0; k < 64; k++) begin
         cond = (t % 4 == 3) && ((ticks + 1) % 2 == 0) && model_phase();
         if (cond) break;
         step("seek_tick");
      end
      chk("tick_found", 16'(cond), 16'd1);
      wr(2'd2, 16'h0002, "tick_wr");
      step("tick_after");
      chk("tick_wr_wins", 16'(ledphys[3:0]), 16'h000F);
      for (int k = 0; k < 12; k++) step("tick_follow");
`endif
      wr(2'd3, 16'h0003, "pre_rst_inv");
`ifdef LED_BLINK_EN
      for (int k = 0; k < 20 && ledphys != 16'h000F; k++) step("seek_dark");
      chk("pre_rst_dark", ledphys, 16'h000F);
`else
      repeat (3) step("pre_rst");
      chk("pre_rst_inv", ledphys, 16'h0000);
`endif
      #2 ledrst = 1'b1;
      #1 chk("async_rst", ledphys, 16'h0000);
      model_reset();
      cfgcs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cfgaddr = 2'(i);
         #1 chk("rst_rd", cfgrdata, model_rd(cfgaddr));
      end
      cfgcs = 1'b0;
      @(posedge ledclk);
      #1 ledrst = 1'b0;
      repeat (20) step("after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
